// File: rtl/barrel_pkg.sv
// Shared encodings and sizing helper for the pipelined barrel shifter.
package barrel_pkg;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Number of pipeline stages; never below one so narrow widths still elaborate.
  function automatic int STAGES(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One registered shift-or-pass stage of the barrel shifter, with its own
// valid bit and a ready that lets bubbles collapse.
module barrel_shift_stage
  import barrel_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int SHIFT     = 1,
  parameter int TAG_W     = 4,
  localparam int SEL_W    = STAGES(DATA_SIZE),
  localparam int BIT      = $clog2(SHIFT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic [SEL_W-1:0]     sel_in,
  input  logic                 dir_in,
  input  logic [1:0]           mode_in,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic [SEL_W-1:0]     sel_out,
  output logic                 dir_out,
  output logic [1:0]           mode_out,
  output logic [TAG_W-1:0]     tag_out
);

  logic [DATA_SIZE-1:0] shifted;

  // Arithmetic right is kept in its own branch so the signed shift is not
  // turned unsigned by mixing it with unsigned operands in one expression.
  always_comb begin
    shifted = data_in;
    if (sel_in[BIT]) begin
      case (mode_in)
        MODE_ROT: begin
          if (dir_in == DIR_RIGHT)
            shifted = (data_in >> SHIFT) | (data_in << (DATA_SIZE - SHIFT));
          else
            shifted = (data_in << SHIFT) | (data_in >> (DATA_SIZE - SHIFT));
        end
        MODE_ARI: begin
          if (dir_in == DIR_RIGHT)
            shifted = $signed(data_in) >>> SHIFT;
          else
            shifted = data_in << SHIFT;
        end
        default: begin
          if (dir_in == DIR_RIGHT)
            shifted = data_in >> SHIFT;
          else
            shifted = data_in << SHIFT;
        end
      endcase
    end
  end

  assign ready_out = !valid_out || ready_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      sel_out   <= '0;
      dir_out   <= DIR_LEFT;
      mode_out  <= MODE_LOG;
      tag_out   <= '0;
    end else if (ready_out) begin
      valid_out <= valid_in;
      data_out  <= shifted;
      sel_out   <= sel_in;
      dir_out   <= dir_in;
      mode_out  <= mode_in;
      tag_out   <= tag_in;
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Fully pipelined barrel shifter: one stage per select bit, run-time direction
// and mode, valid/ready backpressure and a tag carried alongside the data.
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int TAG_W     = 4,
  localparam int S        = STAGES(DATA_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic [S-1:0]         select,
  input  logic                 dir,
  input  logic [1:0]           mode,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] data_out,
  output logic [TAG_W-1:0]     tag_out
);

  if (DATA_SIZE < 2 || (DATA_SIZE & (DATA_SIZE - 1)) != 0) begin : g_bad_size
    $error("barrel_shifter_pipe: DATA_SIZE must be a power of two >= 2");
  end

  // Index 0 is the input port side, index S the output port side.
  logic                 valid_s [0:S];
  logic                 ready_s [0:S];
  logic [DATA_SIZE-1:0] data_s  [0:S];
  logic [S-1:0]         sel_s   [0:S];
  logic                 dir_s   [0:S];
  logic [1:0]           mode_s  [0:S];
  logic [TAG_W-1:0]     tag_s   [0:S];

  assign valid_s[0] = in_valid;
  assign data_s[0]  = data_in;
  assign sel_s[0]   = select;
  assign dir_s[0]   = dir;
  assign mode_s[0]  = mode;
  assign tag_s[0]   = tag_in;
  assign ready_s[S] = out_ready;

  for (genvar k = 0; k < S; k++) begin : g_stage
    barrel_shift_stage #(
      .DATA_SIZE (DATA_SIZE),
      .SHIFT     (2 ** k),
      .TAG_W     (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_s[k]),
      .ready_out (ready_s[k]),
      .data_in   (data_s[k]),
      .sel_in    (sel_s[k]),
      .dir_in    (dir_s[k]),
      .mode_in   (mode_s[k]),
      .tag_in    (tag_s[k]),
      .valid_out (valid_s[k+1]),
      .ready_in  (ready_s[k+1]),
      .data_out  (data_s[k+1]),
      .sel_out   (sel_s[k+1]),
      .dir_out   (dir_s[k+1]),
      .mode_out  (mode_s[k+1]),
      .tag_out   (tag_s[k+1])
    );
  end

  assign in_ready  = ready_s[0];
  assign out_valid = valid_s[S];
  assign data_out  = data_s[S];
  assign tag_out   = tag_s[S];

endmodule
